// File: rtl/asip_gfx_pkg.sv
// Shared graphics definitions for the framebuffer fill engine.
// Contents:
//   - canvas constants (ImageWidth, ImageHeight, ColorBits, XBits, YBits)
//   - state_t  : fill engine FSM states
//   - rect_cmd_t : latched rectangle command (origin, size, colour)
package asip_gfx_pkg;

    localparam int ImageWidth  = 320;
    localparam int ImageHeight = 240;
    localparam int ColorBits   = 3;
    localparam int XBits       = 9;
    localparam int YBits       = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        FILL,
        DONE
    } state_t;

    // Width and height carry one extra bit so a full-canvas size fits.
    typedef struct packed {
        logic [XBits-1:0]     x0;
        logic [YBits-1:0]     y0;
        logic [XBits:0]       w;
        logic [YBits:0]       h;
        logic [ColorBits-1:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/fb_rect_if.sv
// Command and pixel-write bundle between a command source (CPU side) and
// the rectangle fill engine, which also drives the pixel-memory write port.
// Signals:
//   cmdValid/cmdReady           command handshake
//   cmdX0/cmdY0/cmdW/cmdH/cmdColor  rectangle command fields
//   writeEnable/XWrite/YWrite/writeValueMemory  pixel-memory write port
//   busy/done/clipped           engine status
// Modports: master = command source, slave = fill engine.
interface fb_rect_if;
    import asip_gfx_pkg::*;

    logic                 cmdValid;
    logic                 cmdReady;
    logic [XBits-1:0]     cmdX0;
    logic [YBits-1:0]     cmdY0;
    logic [XBits:0]       cmdW;
    logic [YBits:0]       cmdH;
    logic [ColorBits-1:0] cmdColor;
    logic                 writeEnable;
    logic [XBits-1:0]     XWrite;
    logic [YBits-1:0]     YWrite;
    logic [ColorBits-1:0] writeValueMemory;
    logic                 busy;
    logic                 done;
    logic                 clipped;

    modport master (
        output cmdValid, cmdX0, cmdY0, cmdW, cmdH, cmdColor,
        input  cmdReady, writeEnable, XWrite, YWrite, writeValueMemory,
        input  busy, done, clipped
    );

    modport slave (
        input  cmdValid, cmdX0, cmdY0, cmdW, cmdH, cmdColor,
        output cmdReady, writeEnable, XWrite, YWrite, writeValueMemory,
        output busy, done, clipped
    );

endinterface

// File: rtl/fb_raster_counter.sv
// Raster-order X/Y scan counter over an inclusive rectangle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              load origin and inclusive end bounds
//   x_start, y_start   first column / row
//   x_last, y_last     last column / row (inclusive)
//   advance            step to the next pixel (X inner, Y outer)
//   x, y               current position (holds when idle)
//   last               current position is the final pixel of the rectangle
module fb_raster_counter
    import asip_gfx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [XBits-1:0] x_start,
    input  logic [YBits-1:0] y_start,
    input  logic [XBits-1:0] x_last,
    input  logic [YBits-1:0] y_last,
    input  logic             advance,
    output logic [XBits-1:0] x,
    output logic [YBits-1:0] y,
    output logic             last
);

    logic [XBits-1:0] x_reg;
    logic [YBits-1:0] y_reg;
    logic [XBits-1:0] x_first_reg;
    logic [XBits-1:0] x_last_reg;
    logic [YBits-1:0] y_last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg       <= '0;
            y_reg       <= '0;
            x_first_reg <= '0;
            x_last_reg  <= '0;
            y_last_reg  <= '0;
        end else if (start) begin
            x_reg       <= x_start;
            y_reg       <= y_start;
            x_first_reg <= x_start;
            x_last_reg  <= x_last;
            y_last_reg  <= y_last;
        end else if (advance) begin
            // Row wrap returns to the rectangle's left edge, not column 0.
            if (x_reg == x_last_reg) begin
                x_reg <= x_first_reg;
                y_reg <= y_reg + YBits'(1);
            end else begin
                x_reg <= x_reg + XBits'(1);
            end
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = (x_reg == x_last_reg) && (y_reg == y_last_reg);

endmodule

// File: rtl/fb_rect_writer.sv
// Framebuffer rectangle fill engine. Accepts one command (origin, size,
// colour), clips it to the canvas, then issues one pixel write per clock
// in raster order.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous active-low reset
//   bus    fb_rect_if.slave: command handshake, pixel write port, status
// Timing: accept edge -> CLIP (1 cycle) -> FILL (one write per cycle) or
// straight to DONE when the clipped area is empty -> DONE (done pulse) -> IDLE.
module fb_rect_writer
    import asip_gfx_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    fb_rect_if.slave bus
);

    localparam logic [XBits+1:0] XLimit = (XBits+2)'(ImageWidth);
    localparam logic [YBits+1:0] YLimit = (YBits+2)'(ImageHeight);

    state_t    state_reg;
    rect_cmd_t cmd_reg;

    logic [XBits+1:0] x_sum;
    logic [YBits+1:0] y_sum;
    logic             x_limited;
    logic             y_limited;
    logic             empty;
    logic [XBits-1:0] x_last;
    logic [YBits-1:0] y_last;
    logic             cnt_start;
    logic             cnt_advance;
    logic             cnt_last;

    // Clip arithmetic on the latched command; only consumed in CLIP.
    // Sums are two bits wider than the coordinates so they cannot wrap.
    always_comb begin
        x_sum     = {2'b00, cmd_reg.x0} + {1'b0, cmd_reg.w};
        y_sum     = {2'b00, cmd_reg.y0} + {1'b0, cmd_reg.h};
        x_limited = x_sum > XLimit;
        y_limited = y_sum > YLimit;
        empty     = (cmd_reg.w == '0) || (cmd_reg.h == '0) ||
                    (cmd_reg.x0 >= XBits'(ImageWidth)) ||
                    (cmd_reg.y0 >= YBits'(ImageHeight));
        // Inclusive last column/row; only meaningful when not empty.
        x_last    = x_limited ? XBits'(ImageWidth - 1)
                              : XBits'(x_sum - (XBits+2)'(1));
        y_last    = y_limited ? YBits'(ImageHeight - 1)
                              : YBits'(y_sum - (YBits+2)'(1));
        cnt_start   = (state_reg == CLIP) && !empty;
        cnt_advance = (state_reg == FILL) && !cnt_last;
    end

    // The counter registers are the write address outputs, so the address
    // holds its last value outside FILL and clears on reset.
    fb_raster_counter u_counter (
        .clk     (clk),
        .rst_n   (reset),
        .start   (cnt_start),
        .x_start (cmd_reg.x0),
        .y_start (cmd_reg.y0),
        .x_last  (x_last),
        .y_last  (y_last),
        .advance (cnt_advance),
        .x       (bus.XWrite),
        .y       (bus.YWrite),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg            <= IDLE;
            cmd_reg              <= '0;
            bus.cmdReady         <= 1'b1;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.clipped          <= 1'b0;
            bus.writeEnable      <= 1'b0;
            bus.writeValueMemory <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmdValid) begin
                        cmd_reg      <= '{x0: bus.cmdX0, y0: bus.cmdY0,
                                          w: bus.cmdW, h: bus.cmdH,
                                          color: bus.cmdColor};
                        state_reg    <= CLIP;
                        bus.cmdReady <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.clipped  <= 1'b0;
                    end
                end
                CLIP: begin
                    if (empty) begin
                        state_reg   <= DONE;
                        bus.done    <= 1'b1;
                        bus.clipped <= 1'b1;
                    end else begin
                        state_reg            <= FILL;
                        bus.writeEnable      <= 1'b1;
                        bus.writeValueMemory <= cmd_reg.color;
                        bus.clipped          <= x_limited || y_limited;
                    end
                end
                FILL: begin
                    if (cnt_last) begin
                        state_reg       <= DONE;
                        bus.writeEnable <= 1'b0;
                        bus.done        <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    bus.done     <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.cmdReady <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
